uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between two byte-producing requesters. Round-robin arbitration, byte latching into a hold register, the start/done handshake with the transmitter, and a watchdog timeout on the transmitter's done tick. Sits between the TX-side producers (e.g. command responder and debug logger) and the UART transmitter core.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_tmo_counter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX arbiters: FSM encoding and default timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Cycles to wait for the transmitter's done tick before giving up.
  localparam int unsigned TMO_DEFAULT   = 32'd4096;
  localparam int unsigned TMO_W_DEFAULT = 32'd13;

  // Round-robin pointer update: the requester that was not just served goes next.
  function automatic logic other_idx(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_tmo_counter.sv
// Watchdog counter: cleared at transaction start, counts while enabled, flags the terminal count.
module tmo_counter
  import uart_pkg::*;
#(
  parameter int unsigned TMO   = TMO_DEFAULT,
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO - 32'd1);
  localparam logic [TMO_W-1:0] ONE  = TMO_W'(32'd1);

  logic [TMO_W-1:0] count_r;

  // Count register with synchronous active-low reset and synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte producers,
// with a hold register for the granted byte and a watchdog on the done tick.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned TMO   = TMO_DEFAULT,
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] din0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] din1,
  output logic         ack1,
  output logic         tx_start,
  output logic [W-1:0] tx_dout,
  input  logic         tx_done_tick,
  output logic         busy,
  output logic         grant,
  output logic         tx_err
);

  state_t         state_r;
  state_t         state_nxt_s;
  logic           ptr_r;
  logic           grant_r;
  logic [W-1:0]   hold_r;
  logic           tx_err_r;
  logic           sel_s;
  logic           take_s;
  logic           tmo_fire_s;
  logic           expired_s;
  logic           cnt_clr_s;
  logic           cnt_en_s;

  tmo_counter #(
    .TMO   (TMO),
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .expired (expired_s)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic, requester selection and timeout detection.
  always_comb begin
    state_nxt_s = state_r;
    sel_s       = 1'b0;
    take_s      = 1'b0;
    tmo_fire_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          take_s = 1'b1;
          sel_s  = ptr_r;
        end else if (req0) begin
          take_s = 1'b1;
          sel_s  = 1'b0;
        end else if (req1) begin
          take_s = 1'b1;
          sel_s  = 1'b1;
        end else begin
          take_s = 1'b0;
          sel_s  = 1'b0;
        end
        if (take_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A done tick on the terminal-count cycle takes priority over the timeout.
        if (tx_done_tick) begin
          state_nxt_s = ST_IDLE;
        end else if (expired_s) begin
          state_nxt_s = ST_IDLE;
          tmo_fire_s  = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Hold register, grant, round-robin pointer and error pulse register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_r   <= '0;
      grant_r  <= 1'b0;
      ptr_r    <= 1'b0;
      tx_err_r <= 1'b0;
    end else begin
      tx_err_r <= tmo_fire_s;
      if (take_s) begin
        hold_r  <= sel_s ? din1 : din0;
        grant_r <= sel_s;
        ptr_r   <= other_idx(sel_s);
      end else begin
        hold_r  <= hold_r;
        grant_r <= grant_r;
        ptr_r   <= ptr_r;
      end
    end
  end

  // Moore output decode from the registered state and grant.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    tx_start  = 1'b0;
    busy      = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_START: begin
        busy      = 1'b1;
        tx_start  = 1'b1;
        cnt_clr_s = 1'b1;
        if (grant_r) begin
          ack1 = 1'b1;
        end else begin
          ack0 = 1'b1;
        end
      end
      ST_WAIT: begin
        busy     = 1'b1;
        cnt_en_s = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign tx_dout = hold_r;
  assign grant   = grant_r;
  assign tx_err  = tx_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one instance with the default timeout,
// one with TMO=8 for the watchdog cases.
module tb_uart_tx_arbiter;

  typedef struct {
    bit         is_err;
    bit         g;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default timeout
  logic       reset_a = 1'b0, req0_a = 1'b0, req1_a = 1'b0, done_a = 1'b0;
  logic [7:0] din0_a = 8'h00, din1_a = 8'h00;
  logic       ack0_a, ack1_a, tx_start_a, busy_a, grant_a, tx_err_a;
  logic [7:0] tx_dout_a;

  // Instance B: short timeout
  logic       reset_b = 1'b0, req0_b = 1'b0, req1_b = 1'b0, done_b = 1'b0;
  logic [7:0] din0_b = 8'h00, din1_b = 8'h00;
  logic       ack0_b, ack1_b, tx_start_b, busy_b, grant_b, tx_err_b;
  logic [7:0] tx_dout_b;

  uart_tx_arbiter #(.W(8), .TMO(4096), .TMO_W(13)) u_dut_a (
    .clk(clk), .reset(reset_a),
    .req0(req0_a), .din0(din0_a), .ack0(ack0_a),
    .req1(req1_a), .din1(din1_a), .ack1(ack1_a),
    .tx_start(tx_start_a), .tx_dout(tx_dout_a), .tx_done_tick(done_a),
    .busy(busy_a), .grant(grant_a), .tx_err(tx_err_a)
  );

  uart_tx_arbiter #(.W(8), .TMO(8), .TMO_W(4)) u_dut_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .din0(din0_b), .ack0(ack0_b),
    .req1(req1_b), .din1(din1_b), .ack1(ack1_b),
    .tx_start(tx_start_b), .tx_dout(tx_dout_b), .tx_done_tick(done_b),
    .busy(busy_b), .grant(grant_b), .tx_err(tx_err_b)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_start(input bit to_b, input bit g, input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0; e.g = g; e.d = d;
    if (to_b) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic push_err_b();
    exp_t e;
    e.is_err = 1'b1; e.g = 1'b0; e.d = 8'h00;
    qb.push_back(e);
  endtask

  // Bounded wait for a start pulse on instance A; returns cycles waited.
  task automatic wait_start_a(output int n);
    n = 0;
    while (tx_start_a !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk("start_seen_a", {31'd0, tx_start_a}, 32'd1);
  endtask

  // Monitor A: every start/ack/err presented is checked against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (tx_start_a === 1'b1 || tx_err_a === 1'b1 || ack0_a === 1'b1 || ack1_a === 1'b1) begin
      if (qa.size() == 0) begin
        chk("unexpected_event_a", {28'd0, tx_start_a, tx_err_a, ack0_a, ack1_a}, 32'd0);
      end else begin
        e = qa.pop_front();
        if (e.is_err) begin
          chk("err_a", {31'd0, tx_err_a}, 32'd1);
          chk("err_nostart_a", {31'd0, tx_start_a}, 32'd0);
        end else begin
          chk("start_a", {31'd0, tx_start_a}, 32'd1);
          chk("grant_a", {31'd0, grant_a}, {31'd0, e.g});
          chk("dout_a", {24'd0, tx_dout_a}, {24'd0, e.d});
          chk("ack0_a", {31'd0, ack0_a}, {31'd0, ~e.g});
          chk("ack1_a", {31'd0, ack1_a}, {31'd0, e.g});
        end
      end
    end
  end

  // Monitor B: same scoreboard discipline for the short-timeout instance.
  always @(negedge clk) begin
    exp_t e;
    if (tx_start_b === 1'b1 || tx_err_b === 1'b1 || ack0_b === 1'b1 || ack1_b === 1'b1) begin
      if (qb.size() == 0) begin
        chk("unexpected_event_b", {28'd0, tx_start_b, tx_err_b, ack0_b, ack1_b}, 32'd0);
      end else begin
        e = qb.pop_front();
        if (e.is_err) begin
          chk("err_b", {31'd0, tx_err_b}, 32'd1);
          chk("err_nostart_b", {31'd0, tx_start_b}, 32'd0);
        end else begin
          chk("start_b", {31'd0, tx_start_b}, 32'd1);
          chk("grant_b", {31'd0, grant_b}, {31'd0, e.g});
          chk("dout_b", {24'd0, tx_dout_b}, {24'd0, e.d});
          chk("ack0_b", {31'd0, ack0_b}, {31'd0, ~e.g});
          chk("ack1_b", {31'd0, ack1_b}, {31'd0, e.g});
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout_global actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset both instances.
    tick(2);
    reset_a = 1'b1;
    reset_b = 1'b1;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_grant", {31'd0, grant_a}, 32'd0);
    chk("rst_dout", {24'd0, tx_dout_a}, 32'd0);
    chk("rst_pulses", {28'd0, ack0_a, ack1_a, tx_start_a, tx_err_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);

    // 1. Single request
    req0_a = 1'b1; din0_a = 8'hA5;
    push_start(1'b0, 1'b0, 8'hA5);
    tick(1);
    chk("t1_start_latency", {31'd0, tx_start_a}, 32'd1);
    chk("t1_dout", {24'd0, tx_dout_a}, 32'h0000_00A5);
    chk("t1_busy_start", {31'd0, busy_a}, 32'd1);
    req0_a = 1'b0;
    tick(1);
    chk("t1_start_one_cycle", {30'd0, tx_start_a, ack0_a}, 32'd0);
    chk("t1_busy_wait", {31'd0, busy_a}, 32'd1);
    tick(19);
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    chk("t1_idle_after_done", {31'd0, busy_a}, 32'd0);

    // 6. Stray inputs: done in IDLE, din changing during WAIT
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    chk("t6_idle_done_busy", {31'd0, busy_a}, 32'd0);
    chk("t6_idle_done_dout", {24'd0, tx_dout_a}, 32'h0000_00A5);
    req0_a = 1'b1; din0_a = 8'h5A;
    push_start(1'b0, 1'b0, 8'h5A);
    tick(1);
    req0_a = 1'b0;
    tick(1);
    din0_a = 8'hFF;
    tick(3);
    chk("t6_dout_held", {24'd0, tx_dout_a}, 32'h0000_005A);
    chk("t6_still_wait", {31'd0, busy_a}, 32'd1);
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    chk("t6_idle", {31'd0, busy_a}, 32'd0);

    // Reset pulse to restore ptr=0 before the tie test.
    reset_a = 1'b0;
    tick(1);
    reset_a = 1'b1;
    chk("rst2_dout", {24'd0, tx_dout_a}, 32'd0);

    // 2. Tie and alternation
    req0_a = 1'b1; req1_a = 1'b1; din0_a = 8'h11; din1_a = 8'h22;
    push_start(1'b0, 1'b0, 8'h11);
    push_start(1'b0, 1'b1, 8'h22);
    push_start(1'b0, 1'b0, 8'h11);
    push_start(1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 4; i++) begin
      wait_start_a(n);
      chk("t2_start_spacing", n, 32'd1);
      chk("t2_grant_seq", {31'd0, grant_a}, (i % 2));
      tick(5);
      done_a = 1'b1;
      tick(1);
      done_a = 1'b0;
      chk("t2_idle_after_done", {31'd0, busy_a}, 32'd0);
      if (i == 3) begin
        req0_a = 1'b0; req1_a = 1'b0;
      end
    end
    tick(2);
    chk("t2_quiet", {31'd0, busy_a}, 32'd0);

    // 5. Reset two cycles into WAIT
    req0_a = 1'b1; din0_a = 8'h77;
    push_start(1'b0, 1'b0, 8'h77);
    tick(1);
    req0_a = 1'b0;
    tick(2);
    chk("t5_in_wait", {31'd0, busy_a}, 32'd1);
    reset_a = 1'b0;
    tick(1);
    chk("t5_outputs_zero", {21'd0, busy_a, grant_a, tx_err_a, tx_start_a, ack0_a, ack1_a, 2'b00, 3'b000},
        32'd0);
    chk("t5_dout_zero", {24'd0, tx_dout_a}, 32'd0);
    reset_a = 1'b1;
    done_a = 1'b1;
    tick(1);
    done_a = 1'b0;
    tick(2);
    chk("t5_late_done_idle", {30'd0, busy_a, tx_err_a}, 32'd0);

    // 3. Timeout with TMO=8
    req1_b = 1'b1; din1_b = 8'h3C;
    push_start(1'b1, 1'b1, 8'h3C);
    push_err_b();
    tick(1);
    chk("t3_start", {31'd0, tx_start_b}, 32'd1);
    req1_b = 1'b0;
    tick(8);
    chk("t3_no_err_early", {31'd0, tx_err_b}, 32'd0);
    chk("t3_busy_before_err", {31'd0, busy_b}, 32'd1);
    tick(1);
    chk("t3_err_at_9", {31'd0, tx_err_b}, 32'd1);
    chk("t3_idle_with_err", {31'd0, busy_b}, 32'd0);
    tick(1);
    chk("t3_err_one_cycle", {31'd0, tx_err_b}, 32'd0);

    // 4. Done on terminal count; tie here also shows ptr returned to 0.
    req0_b = 1'b1; req1_b = 1'b1; din0_b = 8'h44; din1_b = 8'h55;
    push_start(1'b1, 1'b0, 8'h44);
    tick(1);
    chk("t4_ptr_zero_grant", {31'd0, grant_b}, 32'd0);
    req0_b = 1'b0; req1_b = 1'b0;
    tick(8);
    done_b = 1'b1;
    tick(1);
    done_b = 1'b0;
    chk("t4_no_err", {31'd0, tx_err_b}, 32'd0);
    chk("t4_idle", {31'd0, busy_b}, 32'd0);
    tick(2);
    chk("t4_still_no_err", {31'd0, tx_err_b}, 32'd0);

    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
